// File: rtl/mem_arb.sv
// Two-requester arbiter in front of the single-port data memory.
// The core (M stage) has priority. The external debug/loader port is
// guaranteed a grant after MAX_WAIT consecutive denied cycles.
// The grant and the memory access happen combinationally in the same cycle.
// Read data comes back registered, with a one-cycle valid pulse.
module mem_arb #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_MEM   = 5,
  parameter int MAX_WAIT  = 4,
  localparam int MEM_SELECT = $clog2(NUM_MEM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [MEM_SELECT-1:0] i_core_addr,
  input  logic [REG_WIDTH-1:0]  i_core_wdata,
  output logic                  o_core_gnt,
  output logic                  o_core_stall,
  output logic [REG_WIDTH-1:0]  o_core_rdata,
  output logic                  o_core_rvalid,
  input  logic                  i_ext_req,
  input  logic                  i_ext_we,
  input  logic [MEM_SELECT-1:0] i_ext_addr,
  input  logic [REG_WIDTH-1:0]  i_ext_wdata,
  output logic                  o_ext_gnt,
  output logic [REG_WIDTH-1:0]  o_ext_rdata,
  output logic                  o_ext_rvalid,
  output logic                  o_err,
  output logic                  o_mem_we,
  output logic [MEM_SELECT-1:0] o_mem_select,
  output logic [REG_WIDTH-1:0]  o_mem_wdata,
  input  logic [REG_WIDTH-1:0]  i_mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_EXT  = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [WAIT_W-1:0]      wait_cnt_r, wait_cnt_s;
  logic                   core_gnt_s, ext_gnt_s, granted_s;
  logic [MEM_SELECT-1:0]  sel_s;
  logic [REG_WIDTH-1:0]   wdata_s, rd_val_s;
  logic                   acc_we_s, in_range_s, mem_we_s;
  logic                   rd_r, err_r;
  logic [REG_WIDTH-1:0]   core_rdata_r, ext_rdata_r;

  // Checks that a word address points at a real memory word.
  function automatic logic addr_ok(input logic [MEM_SELECT-1:0] addr);
    addr_ok = ({{(32-MEM_SELECT){1'b0}}, addr} < 32'(NUM_MEM));
  endfunction

  // Arbitration: the core wins unless the external port has waited MAX_WAIT cycles.
  always_comb begin
    core_gnt_s = 1'b0;
    ext_gnt_s  = 1'b0;
    if (rst) begin
      core_gnt_s = 1'b0;
      ext_gnt_s  = 1'b0;
    end else if (i_ext_req && (!i_core_req || (wait_cnt_r == WAIT_MAX))) begin
      ext_gnt_s = 1'b1;
    end else if (i_core_req) begin
      core_gnt_s = 1'b1;
    end else begin
      core_gnt_s = 1'b0;
      ext_gnt_s  = 1'b0;
    end
  end

  // Route the granted requester onto the memory port. Drive zeros when idle.
  always_comb begin
    sel_s    = {MEM_SELECT{1'b0}};
    wdata_s  = {REG_WIDTH{1'b0}};
    acc_we_s = 1'b0;
    case ({core_gnt_s, ext_gnt_s})
      2'b10: begin
        sel_s    = i_core_addr;
        wdata_s  = i_core_wdata;
        acc_we_s = i_core_we;
      end
      2'b01: begin
        sel_s    = i_ext_addr;
        wdata_s  = i_ext_wdata;
        acc_we_s = i_ext_we;
      end
      default: begin
        sel_s    = {MEM_SELECT{1'b0}};
        wdata_s  = {REG_WIDTH{1'b0}};
        acc_we_s = 1'b0;
      end
    endcase
  end

  assign granted_s  = core_gnt_s | ext_gnt_s;
  assign in_range_s = addr_ok(sel_s);
  assign mem_we_s   = granted_s & acc_we_s & in_range_s;
  assign rd_val_s   = in_range_s ? i_mem_rdata : {REG_WIDTH{1'b0}};

  // Compute the next state and the next starvation counter value.
  always_comb begin
    state_s    = ST_IDLE;
    wait_cnt_s = {WAIT_W{1'b0}};
    if (i_ext_req && !ext_gnt_s) begin
      if (wait_cnt_r == WAIT_MAX) begin
        wait_cnt_s = WAIT_MAX;
      end else begin
        wait_cnt_s = wait_cnt_r + WAIT_W'(1);
      end
    end else begin
      wait_cnt_s = {WAIT_W{1'b0}};
    end
    case ({core_gnt_s, ext_gnt_s})
      2'b10:   state_s = ST_CORE;
      2'b01:   state_s = ST_EXT;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter, read-return and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= {WAIT_W{1'b0}};
      rd_r         <= 1'b0;
      err_r        <= 1'b0;
      core_rdata_r <= {REG_WIDTH{1'b0}};
      ext_rdata_r  <= {REG_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      rd_r       <= granted_s & ~acc_we_s;
      err_r      <= granted_s & ~in_range_s;
      if (core_gnt_s && !i_core_we) begin
        core_rdata_r <= rd_val_s;
      end else begin
        core_rdata_r <= core_rdata_r;
      end
      if (ext_gnt_s && !i_ext_we) begin
        ext_rdata_r <= rd_val_s;
      end else begin
        ext_rdata_r <= ext_rdata_r;
      end
    end
  end

  assign o_core_gnt    = core_gnt_s;
  assign o_ext_gnt     = ext_gnt_s;
  assign o_core_stall  = i_core_req & ~core_gnt_s;
  assign o_mem_we      = mem_we_s;
  assign o_mem_select  = sel_s;
  assign o_mem_wdata   = wdata_s;
  // A read granted just before reset rises must not produce a pulse, so
  // the returned values are gated by reset.
  assign o_core_rvalid = ~rst & rd_r & (state_r == ST_CORE);
  assign o_ext_rvalid  = ~rst & rd_r & (state_r == ST_EXT);
  assign o_err         = ~rst & err_r;
  assign o_core_rdata  = rst ? {REG_WIDTH{1'b0}} : core_rdata_r;
  assign o_ext_rdata   = rst ? {REG_WIDTH{1'b0}} : ext_rdata_r;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mem_arb;
  localparam int RW = 32;
  localparam int NM = 5;
  localparam int MW = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_core_req = 1'b0, i_core_we = 1'b0;
  logic [AW-1:0] i_core_addr = '0;
  logic [RW-1:0] i_core_wdata = '0;
  logic i_ext_req = 1'b0, i_ext_we = 1'b0;
  logic [AW-1:0] i_ext_addr = '0;
  logic [RW-1:0] i_ext_wdata = '0;
  logic o_core_gnt, o_core_stall, o_core_rvalid;
  logic [RW-1:0] o_core_rdata, o_ext_rdata;
  logic o_ext_gnt, o_ext_rvalid, o_err, o_mem_we;
  logic [AW-1:0] o_mem_select;
  logic [RW-1:0] o_mem_wdata;
  logic [RW-1:0] i_mem_rdata;

  logic [RW-1:0] env_mem [NM];

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  // reference model state
  int m_wait;
  logic [RW-1:0] ref_mem [NM];
  bit m_crv, m_erv, m_err;
  logic [RW-1:0] m_crd, m_erd;

  always #5 clk = ~clk;

  mem_arb #(.REG_WIDTH(RW), .NUM_MEM(NM), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_core_req(i_core_req), .i_core_we(i_core_we),
    .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
    .o_core_gnt(o_core_gnt), .o_core_stall(o_core_stall),
    .o_core_rdata(o_core_rdata), .o_core_rvalid(o_core_rvalid),
    .i_ext_req(i_ext_req), .i_ext_we(i_ext_we),
    .i_ext_addr(i_ext_addr), .i_ext_wdata(i_ext_wdata),
    .o_ext_gnt(o_ext_gnt), .o_ext_rdata(o_ext_rdata), .o_ext_rvalid(o_ext_rvalid),
    .o_err(o_err), .o_mem_we(o_mem_we), .o_mem_select(o_mem_select),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  // memory: combinational read, write at the clock edge
  always_comb begin
    if (int'(o_mem_select) < NM) i_mem_rdata = env_mem[o_mem_select];
    else i_mem_rdata = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (o_mem_we && int'(o_mem_select) < NM) env_mem[o_mem_select] <= o_mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: compare every cycle, then advance by one edge.
  always @(negedge clk) begin
    bit eg_c, eg_e, w, inr;
    int a;
    logic [RW-1:0] rdv, wd;
    if (checking) begin
      eg_c = 1'b0;
      eg_e = 1'b0;
      if (!rst) begin
        if (i_ext_req && (!i_core_req || m_wait >= MW)) eg_e = 1'b1;
        else if (i_core_req) eg_c = 1'b1;
      end
      a   = eg_c ? int'(i_core_addr) : (eg_e ? int'(i_ext_addr) : 0);
      w   = eg_c ? i_core_we : (eg_e ? i_ext_we : 1'b0);
      wd  = eg_c ? i_core_wdata : i_ext_wdata;
      inr = (a < NM);
      rdv = inr ? ref_mem[a] : 32'd0;

      chk("core_gnt", o_core_gnt, eg_c);
      chk("ext_gnt", o_ext_gnt, eg_e);
      chk("core_stall", o_core_stall, i_core_req && !eg_c);
      chk("mem_select", o_mem_select, a);
      chk("mem_we", o_mem_we, (eg_c || eg_e) && w && inr);
      if ((eg_c || eg_e) && w) chk("mem_wdata", o_mem_wdata, wd);
      chk("core_rvalid", o_core_rvalid, rst ? 1'b0 : m_crv);
      chk("ext_rvalid", o_ext_rvalid, rst ? 1'b0 : m_erv);
      chk("err", o_err, rst ? 1'b0 : m_err);
      chk("core_rdata", o_core_rdata, rst ? 32'd0 : m_crd);
      chk("ext_rdata", o_ext_rdata, rst ? 32'd0 : m_erd);

      if (rst) begin
        m_wait = 0; m_crv = 0; m_erv = 0; m_err = 0; m_crd = '0; m_erd = '0;
      end else begin
        m_crv = eg_c && !w;
        m_erv = eg_e && !w;
        if (m_crv) m_crd = rdv;
        if (m_erv) m_erd = rdv;
        m_err = (eg_c || eg_e) && !inr;
        if ((eg_c || eg_e) && w && inr) ref_mem[a] = wd;
        if (i_ext_req && !eg_e) m_wait = (m_wait >= MW) ? MW : m_wait + 1;
        else m_wait = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input bit r, input bit w, input int ad, input logic [RW-1:0] d);
    i_core_req = r; i_core_we = w; i_core_addr = AW'(ad); i_core_wdata = d;
  endtask

  task automatic set_ext(input bit r, input bit w, input int ad, input logic [RW-1:0] d);
    i_ext_req = r; i_ext_we = w; i_ext_addr = AW'(ad); i_ext_wdata = d;
  endtask

  initial begin
    bit gc, ge;
    for (int i = 0; i < NM; i++) begin
      env_mem[i] = RW'(2 * i);
      ref_mem[i] = RW'(2 * i);
    end
    m_wait = 0; m_crv = 0; m_erv = 0; m_err = 0; m_crd = '0; m_erd = '0;
    rst = 1'b1;
    tick();
    checking = 1'b1;
    tick();
    #1 chk("rst_core_rvalid", o_core_rvalid, 1'b0);
    chk("rst_core_rdata", o_core_rdata, 32'd0);
    tick();
    rst = 1'b0;

    // core read of mem[1] = 2
    tick();
    set_core(1, 0, 1, 0);
    #1 chk("s1_gnt", o_core_gnt, 1'b1);
    chk("s1_sel", o_mem_select, 3'd1);
    tick();
    set_core(0, 0, 0, 0);
    #1 chk("s1_rvalid", o_core_rvalid, 1'b1);
    chk("s1_rdata", o_core_rdata, 32'd2);
    chk("s1_ext_rvalid", o_ext_rvalid, 1'b0);

    // external write then read back
    tick();
    set_ext(1, 1, 3, 32'hAB);
    #1 chk("s2_we", o_mem_we, 1'b1);
    chk("s2_sel", o_mem_select, 3'd3);
    tick();
    set_ext(1, 0, 3, 0);
    #1 chk("s2_gnt", o_ext_gnt, 1'b1);
    tick();
    set_ext(0, 0, 0, 0);
    #1 chk("s2_rvalid", o_ext_rvalid, 1'b1);
    chk("s2_rdata", o_ext_rdata, 32'hAB);

    // starvation bound: ext wins every fifth cycle
    tick();
    set_core(1, 0, 2, 0);
    set_ext(1, 0, 4, 0);
    for (int k = 0; k < 10; k++) begin
      #1 chk("s3_core_gnt", o_core_gnt, (k % 5) != 4);
      chk("s3_ext_gnt", o_ext_gnt, (k % 5) == 4);
      chk("s3_stall", o_core_stall, (k % 5) == 4);
      tick();
    end
    set_core(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);

    // out-of-range accesses
    tick();
    set_ext(1, 1, 5, 32'h55);
    #1 chk("s4_gnt", o_ext_gnt, 1'b1);
    chk("s4_we", o_mem_we, 1'b0);
    tick();
    set_ext(1, 0, 7, 0);
    #1 chk("s4_err_w", o_err, 1'b1);
    tick();
    set_ext(0, 0, 0, 0);
    #1 chk("s4_rvalid", o_ext_rvalid, 1'b1);
    chk("s4_rdata", o_ext_rdata, 32'd0);
    chk("s4_err_r", o_err, 1'b1);
    tick();
    #1 chk("s4_err_clr", o_err, 1'b0);

    // read-after-write on the core port
    set_core(1, 1, 0, 32'd9);
    tick();
    set_core(1, 0, 0, 0);
    tick();
    set_core(0, 0, 0, 0);
    #1 chk("s5_rvalid", o_core_rvalid, 1'b1);
    chk("s5_rdata", o_core_rdata, 32'd9);

    // reset right after a granted read
    tick();
    set_core(1, 0, 1, 0);
    #1 chk("s6_gnt", o_core_gnt, 1'b1);
    tick();
    rst = 1'b1;
    set_core(0, 0, 0, 0);
    #1 chk("s6_rvalid", o_core_rvalid, 1'b0);
    chk("s6_rdata", o_core_rdata, 32'd0);
    tick();
    #1 chk("s6_rvalid2", o_core_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    set_core(1, 0, 1, 0);
    #1 chk("s6_gnt2", o_core_gnt, 1'b1);
    tick();
    set_core(0, 0, 0, 0);
    #1 chk("s6_rvalid3", o_core_rvalid, 1'b1);
    chk("s6_rdata3", o_core_rdata, 32'd2);

    // randomized traffic, requests held until granted
    for (int n = 0; n < 3000; n++) begin
      #1;
      gc = o_core_gnt;
      ge = o_ext_gnt;
      tick();
      rst = ($urandom % 100) == 0;
      if (!i_core_req || gc)
        set_core(($urandom % 5) != 0, $urandom % 2, $urandom % 8, $urandom);
      if (!i_ext_req || ge)
        set_ext(($urandom % 4) != 0, $urandom % 2, $urandom % 8, $urandom);
    end
    tick();
    set_core(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
Two-requester arbiter for the single-port data memory (reg_bank_mono instance MEM) of the pipelined core.
- Requester 0 is the pipeline M stage.
- Requester 1 is an external debug/loader port used to preload or inspect data memory while the core runs.
- The core has priority, with a bounded-starvation guarantee for the external port and a stall output back to the core's hazard logic.
- Read data is registered and returned with a valid pulse one cycle after grant.

Parameters:
- REG_WIDTH, 32, data word width.
- NUM_MEM, 5, number of memory words.
- MAX_WAIT, 4, consecutive denied cycles after which the external request is forcibly granted (>=1).
- Derived localparam MEM_SELECT = $clog2(NUM_MEM).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_core_req  in  1  core access request (M stage load or store)
- i_core_we  in  1  1 = write, 0 = read
- i_core_addr  in  MEM_SELECT  core word address
- i_core_wdata  in  REG_WIDTH  core write data
- o_core_gnt  out  1  core access performed this cycle
- o_core_stall  out  1  i_core_req & ~o_core_gnt; freezes PC/pipe regs
- o_core_rdata  out  REG_WIDTH  registered read data
- o_core_rvalid  out  1  o_core_rdata valid (one-cycle pulse)
- i_ext_req, i_ext_we, i_ext_addr, i_ext_wdata  in  1/1/MEM_SELECT/REG_WIDTH  external request, same meaning as the core port
- o_ext_gnt, o_ext_rdata, o_ext_rvalid  out  1/REG_WIDTH/1  external grant and read return
- o_err  out  1  registered pulse: granted access had address >= NUM_MEM
- o_mem_we  out  1  memory write enable
- o_mem_select  out  MEM_SELECT  memory address
- o_mem_wdata  out  REG_WIDTH  memory write data
- i_mem_rdata  in  REG_WIDTH  memory combinational read data

Behaviour:
- Grant is combinational from the requests, wait_cnt and state; the memory access occurs in the same cycle as the grant.
- Priority:
  - Only one requester asserting: that requester is granted.
  - Both asserting: core wins unless wait_cnt == MAX_WAIT, in which case ext wins.
  - At most one gnt is high in any cycle.
- wait_cnt (0..MAX_WAIT) updates every cycle:
  - Increments when i_ext_req & ~o_ext_gnt, saturating at MAX_WAIT.
  - Clears on ext grant or when i_ext_req = 0.
- Memory side:
  - o_mem_select and o_mem_wdata are muxed from the granted requester.
  - o_mem_select = 0 when nothing is granted.
  - o_mem_we = gnt & we & (addr < NUM_MEM).
- Out-of-range address (addr >= NUM_MEM):
  - Write is suppressed.
  - Read returns 0.
  - o_err pulses next cycle.
  - The gnt/rvalid handshake completes normally.
- State register, updated each cycle:
  - IDLE: no grant.
  - CORE: core granted last cycle.
  - EXT: ext granted last cycle.
  - Transitions: next state = CORE if o_core_gnt, EXT if o_ext_gnt, else IDLE.
- Read return:
  - On a granted read, rdata is registered at the clock edge.
  - The matching o_*_rvalid is high for exactly the next cycle (state CORE or EXT with a read).
  - Writes produce no rvalid.
  - o_*_rdata holds its last value when rvalid = 0.
- Back-to-back accesses from the same requester are allowed every cycle (full throughput).
- o_core_stall is combinational. The requester must hold req, we, addr and wdata stable until gnt.
- Read-after-write to the same address in consecutive cycles returns the new data (the memory write lands at the edge before the read).
- Reset, synchronous, active-high:
  - state = IDLE, wait_cnt = 0.
  - o_core_rdata = o_ext_rdata = 0.
  - o_core_rvalid = o_ext_rvalid = o_err = 0.
  - Grants are forced to 0 and o_mem_we = 0 while rst is high.
  - A read granted in the cycle before rst rises produces no rvalid.
  - Memory contents are not touched by this block.

Test Plan:
- Reset, then core read addr 1 with mem[1] = 2 → o_core_gnt = 1 same cycle; next cycle o_core_rvalid = 1, o_core_rdata = 2; o_ext_* idle.
- Ext write addr 3, data 0xAB, core idle → o_mem_we = 1, o_mem_select = 3; then ext read addr 3 → o_ext_rvalid next cycle with 0xAB.
- MAX_WAIT = 4: core and ext requesting continuously → core granted cycles 0–3 (o_core_stall = 0); cycle 4 ext granted, o_core_stall = 1; wait_cnt returns to 0; pattern repeats every 5 cycles.
- Ext write addr 5 (NUM_MEM = 5) → o_mem_we = 0, memory unchanged, o_err = 1 next cycle; ext read addr 7 → o_ext_rdata = 0 with rvalid and o_err.
- Core write addr 0 = 9 followed next cycle by core read addr 0 → o_core_rdata = 9 one cycle later.
- Core read granted, rst asserted the next cycle → o_core_rvalid stays 0, all outputs 0, wait_cnt 0; after rst drops, a fresh request behaves as in scenario 1.
